// File: rtl/tinyqv_data_arbiter_if.sv
// Peripheral data-bus channel: addr, write_n/read_n size codes (11 = none), data and ready.
// The master drives the request fields and the slave returns ready and rdata.
interface tinyqv_data_arbiter_if;
  logic [27:0] addr;
  logic [1:0]  write_n;
  logic [1:0]  read_n;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output addr, write_n, read_n, wdata, input ready, rdata);
  modport slave  (input addr, write_n, read_n, wdata, output ready, rdata);
endinterface

// File: rtl/tinyqv_data_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between requesters A and B; one transaction per grant.
// Grant 1 cycle after request, then pass-through until d.ready or timeout; one IDLE cycle between grants.
module tinyqv_data_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hFFFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  tinyqv_data_arbiter_if.slave  a,
  tinyqv_data_arbiter_if.slave  b,
  tinyqv_data_arbiter_if.master d,
  output logic                  busy,
  output logic                  grant_b,
  output logic                  timeout_err,
  output logic                  timeout_id,
  input  logic                  err_clear
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam bit         TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t     state;
  logic       last;
  logic [7:0] cnt;

  logic a_wr, b_wr, a_req, b_req;
  logic sel_b, granted, sel_req, hit_to, done;
  logic [31:0] done_rdata;

  assign a_wr  = (a.write_n != 2'b11);
  assign b_wr  = (b.write_n != 2'b11);
  assign a_req = a_wr || (a.read_n != 2'b11);
  assign b_req = b_wr || (b.read_n != 2'b11);

  assign sel_b   = (state == GNT_B);
  assign granted = (state != IDLE);
  assign sel_req = sel_b ? b_req : a_req;
  assign hit_to  = TO_EN && granted && sel_req && (cnt == TO_LIMIT) && !d.ready;
  // Ready is suppressed while rst is high so a reset mid-transaction never completes it.
  assign done       = granted && !rst && (d.ready || hit_to);
  assign done_rdata = hit_to ? ERR_DATA : d.rdata;

  assign a.ready = done && !sel_b;
  assign a.rdata = (done && !sel_b) ? done_rdata : 32'h0;
  assign b.ready = done && sel_b;
  assign b.rdata = (done && sel_b) ? done_rdata : 32'h0;

  assign busy    = granted;
  assign grant_b = sel_b;

  // A simultaneous write and read is illegal; the write wins and the read is masked.
  always_comb begin
    d.addr    = '0;
    d.write_n = 2'b11;
    d.read_n  = 2'b11;
    d.wdata   = '0;
    if (state == GNT_A) begin
      d.addr    = a.addr;
      d.write_n = a.write_n;
      d.read_n  = a_wr ? 2'b11 : a.read_n;
      d.wdata   = a.wdata;
    end else if (state == GNT_B) begin
      d.addr    = b.addr;
      d.write_n = b.write_n;
      d.read_n  = b_wr ? 2'b11 : b.read_n;
      d.wdata   = b.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      cnt         <= 8'd0;
      timeout_err <= 1'b0;
      timeout_id  <= 1'b0;
    end else begin
      if (err_clear) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (a_req && (!b_req || last)) state <= GNT_A;
          else if (b_req)                state <= GNT_B;
        end
        GNT_A, GNT_B: begin
          if (d.ready) begin
            state <= IDLE;
            last  <= sel_b;
          end else if (!sel_req) begin
            state <= IDLE;
          end else if (hit_to) begin
            state       <= IDLE;
            last        <= sel_b;
            timeout_err <= 1'b1;
            timeout_id  <= sel_b;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyqv_data_arbiter.sv
// Directed bench for tinyqv_data_arbiter with a completion scoreboard (TIMEOUT_CYCLES = 4).
module tb_tinyqv_data_arbiter;

  typedef struct {
    logic        who;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy, grant_b, timeout_err, timeout_id, err_clear;

  tinyqv_data_arbiter_if a_if ();
  tinyqv_data_arbiter_if b_if ();
  tinyqv_data_arbiter_if d_if ();

  tinyqv_data_arbiter #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hFFFFFFFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a_if),
    .b           (b_if),
    .d           (d_if),
    .busy        (busy),
    .grant_b     (grant_b),
    .timeout_err (timeout_err),
    .timeout_id  (timeout_id),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Compare the completion seen this cycle against the oldest outstanding expectation.
  task automatic sb_pop_check(input string tag);
    exp_t e;
    checks++;
    assert (sbq.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb: observed=empty queue expected=entry", tag);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_rdy"},   e.who ? b_if.ready : a_if.ready, 32'd1);
      chk({tag, "_other"}, e.who ? a_if.ready : b_if.ready, 32'd0);
      chk({tag, "_rdata"}, e.who ? b_if.rdata : a_if.rdata, e.rdata);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1; err_clear = 1'b0;
    a_if.addr = '0; a_if.write_n = 2'b11; a_if.read_n = 2'b11; a_if.wdata = '0;
    b_if.addr = '0; b_if.write_n = 2'b11; b_if.read_n = 2'b11; b_if.wdata = '0;
    d_if.ready = 1'b0; d_if.rdata = '0;

    // Reset state
    do_reset();
    smp();
    chk("rst_busy", busy, 0);
    chk("rst_grant_b", grant_b, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_tid", timeout_id, 0);
    chk("rst_a_ready", a_if.ready, 0);
    chk("rst_b_ready", b_if.ready, 0);
    chk("rst_d_write_n", d_if.write_n, 2'b11);
    chk("rst_d_read_n", d_if.read_n, 2'b11);
    chk("rst_a_rdata", a_if.rdata, 0);

    // Single 32-bit read, d_ready two cycles after grant
    step(); a_if.addr = 28'h8000010; a_if.read_n = 2'b10;
    sbq.push_back('{1'b0, 32'h12345678});
    smp(); chk("t1_c0_read_n", d_if.read_n, 2'b11); chk("t1_c0_busy", busy, 0);
    step(); smp();
    chk("t1_c1_read_n", d_if.read_n, 2'b10);
    chk("t1_c1_addr", d_if.addr, 28'h8000010);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_ready", a_if.ready, 0);
    step(); smp(); chk("t1_c2_ready", a_if.ready, 0);
    step(); d_if.ready = 1'b1; d_if.rdata = 32'h12345678;
    smp(); sb_pop_check("t1_c3");
    step(); a_if.read_n = 2'b11; d_if.ready = 1'b0;
    smp(); chk("t1_c4_busy", busy, 0);

    // Tie from reset and fairness: A, B, A
    do_reset();
    step();
    a_if.addr = 28'h0000100; a_if.read_n = 2'b10;
    b_if.addr = 28'h0000200; b_if.read_n = 2'b10;
    d_if.ready = 1'b1; d_if.rdata = 32'h11111111;
    sbq.push_back('{1'b0, 32'h11111111});
    smp(); chk("t2_c0_busy", busy, 0);
    step(); smp(); chk("t2_c1_grant_b", grant_b, 0); sb_pop_check("t2_a1");
    step(); smp(); chk("t2_c2_busy", busy, 0);
    step(); d_if.rdata = 32'h22222222; sbq.push_back('{1'b1, 32'h22222222});
    smp(); chk("t2_c3_grant_b", grant_b, 1); sb_pop_check("t2_b1");
    step(); b_if.read_n = 2'b11;
    smp(); chk("t2_c4_busy", busy, 0);
    step(); d_if.rdata = 32'h33333333; sbq.push_back('{1'b0, 32'h33333333});
    smp(); chk("t2_c5_grant_b", grant_b, 0); sb_pop_check("t2_a2");
    step(); a_if.read_n = 2'b11; d_if.ready = 1'b0;
    smp(); chk("t2_c6_busy", busy, 0);

    // Zero-latency byte write from B, back-to-back
    step();
    b_if.addr = 28'h8000004; b_if.write_n = 2'b00; b_if.wdata = 32'h000000A5;
    d_if.ready = 1'b1; d_if.rdata = 32'hDEADBEEF;
    sbq.push_back('{1'b1, 32'hDEADBEEF});
    sbq.push_back('{1'b1, 32'hDEADBEEF});
    smp(); chk("t3_c0_busy", busy, 0);
    step(); smp();
    chk("t3_c1_write_n", d_if.write_n, 2'b00);
    chk("t3_c1_wdata", d_if.wdata, 32'h000000A5);
    chk("t3_c1_addr", d_if.addr, 28'h8000004);
    chk("t3_c1_read_n", d_if.read_n, 2'b11);
    sb_pop_check("t3_w1");
    step(); smp(); chk("t3_c2_busy", busy, 0); chk("t3_c2_ready", b_if.ready, 0);
    step(); smp(); sb_pop_check("t3_w2");
    step(); b_if.write_n = 2'b11; d_if.ready = 1'b0;
    smp(); chk("t3_c4_busy", busy, 0);

    // Timeout on A, then err_clear
    step(); a_if.addr = 28'h8000020; a_if.read_n = 2'b10;
    sbq.push_back('{1'b0, 32'hFFFFFFFF});
    smp();
    lat = 0;
    for (int i = 0; i < 20 && !a_if.ready; i++) begin
      step(); smp(); lat++;
    end
    chk("t4_latency", lat, 5);
    sb_pop_check("t4_to");
    step(); a_if.read_n = 2'b11; err_clear = 1'b1;
    smp(); chk("t4_terr", timeout_err, 1); chk("t4_tid", timeout_id, 0); chk("t4_busy", busy, 0);
    step(); err_clear = 1'b0;
    smp(); chk("t4_terr_clr", timeout_err, 0);

    // Timeout on B coinciding with err_clear
    step(); b_if.addr = 28'h8000030; b_if.read_n = 2'b10;
    sbq.push_back('{1'b1, 32'hFFFFFFFF});
    smp();
    step(); step(); step(); step();
    smp(); chk("t6_c4_ready", b_if.ready, 0);
    step(); err_clear = 1'b1;
    smp(); sb_pop_check("t6_to");
    step(); err_clear = 1'b0; b_if.read_n = 2'b11;
    smp(); chk("t6_terr", timeout_err, 1); chk("t6_tid", timeout_id, 1);
    step(); err_clear = 1'b1;
    step(); err_clear = 1'b0;

    // Abort: A drops its request after one granted cycle
    step(); a_if.addr = 28'h8000040; a_if.read_n = 2'b10;
    smp();
    step(); smp(); chk("t5_c1_busy", busy, 1); chk("t5_c1_grant_b", grant_b, 0);
    step(); a_if.read_n = 2'b11;
    smp(); chk("t5_c2_read_n", d_if.read_n, 2'b11); chk("t5_c2_ready", a_if.ready, 0);
    step(); smp(); chk("t5_c3_busy", busy, 0); chk("t5_c3_ready", a_if.ready, 0);

    // Reset during GNT_B
    step(); b_if.addr = 28'h8000050; b_if.read_n = 2'b10;
    smp();
    step(); smp(); chk("t7_c1_grant_b", grant_b, 1);
    step(); rst = 1'b1; d_if.ready = 1'b1; d_if.rdata = 32'h55555555;
    smp(); chk("t7_c2_ready", b_if.ready, 0);
    step(); rst = 1'b0; b_if.read_n = 2'b11; d_if.ready = 1'b0;
    smp();
    chk("t7_c3_busy", busy, 0);
    chk("t7_c3_grant_b", grant_b, 0);
    chk("t7_c3_read_n", d_if.read_n, 2'b11);
    chk("t7_c3_write_n", d_if.write_n, 2'b11);
    chk("t7_c3_ready", b_if.ready, 0);

    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
